regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 16-entry register file. The ALU result path and the memory-load path share the single register-file write port, and this block selects one of them per cycle. It registers the winning write and presents `wb_rdest`/`wb_data`/`wb_en` to the Rdest-to-enable decoder and the register bank. Starvation of the ALU path is bounded by a loss counter.

## Interface
- `DATA_W`, 16, write-data width
- `ADDR_W`, 4, register address width (16 registers)
- `MAX_WAIT`, 2, consecutive ALU losses before ALU is forced to win (range 1..3)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU write request
- `alu_rdest`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU request accepted this cycle
- `mem_valid`  in  1  load write request
- `mem_rdest`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `mem_ready`  out  1  load request accepted this cycle
- `wb_en`  out  1  registered write strobe to the register file
- `wb_rdest`  out  ADDR_W  registered destination; drives the Rdest decoder
- `wb_data`  out  DATA_W  registered write data
- `alu_starved`  out  1  high while the force state is active

## Operation
- A request transfers on a cycle where `X_valid && X_ready`. Requesters hold `rdest`/`data` stable while valid and not ready.
- `X_ready` is combinational from the valids and the state. At most one ready is high per cycle, except for Rdest-0 requests.
- Rdest 0 is the null destination. Such a request gets ready immediately in the same cycle, consumes no write slot and produces no `wb_en`. Two simultaneous Rdest-0 requests both get ready.
- FSM states:
  - ARB (reset state): if `mem_valid` is high, mem wins, else ALU wins.
  - FORCE: ALU wins over mem.
- Loss counter (2 bits), counting only non-null ALU requests:
  - increments on each cycle where a non-null ALU request is valid and loses;
  - clears when ALU is granted;
  - on reaching `MAX_WAIT`, the FSM goes ARB→FORCE;
  - FORCE→ARB on the ALU grant; the counter clears at the same time.
- Same-register collision (both valid, same non-zero rdest):
  - mem always wins, in either state; ALU writes the following cycle, so the ALU value is final;
  - the losing cycle does not increment the counter in FORCE.
- With no valid request, the FSM holds its state and the counter holds its value.
- `alu_starved` = (state == FORCE).

## Timing
- Latency: a transfer in cycle N produces `wb_en`=1 with the matching `wb_rdest`/`wb_data` in cycle N+1. Throughput is one write per cycle.
- `wb_en` is low in any cycle following no non-null transfer. `wb_rdest`/`wb_data` hold their last value when `wb_en` is low.
- Reset values:
  - `wb_en`=0, `wb_rdest`=0, `wb_data`=0;
  - state=ARB, counter=0, `alu_starved`=0;
  - `alu_ready` and `mem_ready` are forced to 0 while `reset` is high.
- Reset mid-operation: a write registered before reset is dropped (`wb_en` clears asynchronously). A requester that was not granted must re-present its request after reset.
- Worst-case ALU wait under continuous load traffic is `MAX_WAIT` cycles, excluding collision cycles.

## Structure
- Shared CPU package:
  - `REG_NONE` = 4'd0;
  - FSM state encoding `WB_ARB`/`WB_FORCE`;
  - `DATA_W`/`ADDR_W` defaults.
- One natural sub-module: `wb_grant`, the combinational grant logic (inputs: valids, rdests, state; outputs: grants and the null-accept signals).
- State, counter and output registers stay in the top module.
- The Rdest decoder is instantiated downstream of this block, not inside it.

## Test plan
- ALU only: ALU rdest=5, data=0x1234 → `alu_ready`=1 the same cycle; next cycle `wb_en`=1, `wb_rdest`=5, `wb_data`=0x1234.
- Continuous load traffic, `MAX_WAIT`=2: mem valid every cycle (rdest=3), ALU valid (rdest=7) → mem, mem, then ALU granted on the 3rd cycle; `alu_starved`=1 during that 3rd cycle, then 0.
- Collision: both valid, rdest=9; mem=0x00AA, ALU=0x00BB → `wb_data` is 0x00AA then 0x00BB on consecutive cycles; the counter does not trip FORCE.
- Null destination: ALU rdest=0 together with mem rdest=4 → both readies high; only the mem write appears (`wb_rdest`=4); `wb_en` is never asserted for rdest 0.
- Reset mid-stream: assert `reset` the cycle after a grant → `wb_en` drops to 0 immediately; state=ARB and counter=0 after release; readies are 0 throughout reset.
- Idle hold: ALU loses once, all valids then drop for 5 cycles, then mem and ALU are valid again → mem wins, ALU is forced on the next cycle (the counter was preserved).

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: null destination,
// arbiter state encoding and default datapath widths.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Register 0 is the null destination; writes to it are accepted and discarded
  localparam logic [3:0] REG_NONE = 4'd0;

  typedef enum logic {
    WB_ARB   = 1'b0,
    WB_FORCE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_grant.sv
// Combinational grant logic for the shared register-file write port.
// Decides which non-null request wins this cycle, accepts null-destination
// requests immediately, and flags an ALU loss that should bump the loss counter.
module wb_grant
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rdest,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rdest,
  input  logic              force_alu,
  output logic              alu_grant,
  output logic              mem_grant,
  output logic              alu_null_ok,
  output logic              mem_null_ok,
  output logic              alu_lost
);

  logic alu_req;
  logic mem_req;
  logic collision;

  // Same-register collisions always go to mem so the ALU value lands last;
  // otherwise mem wins in ARB and the ALU wins while forced.
  always_comb begin
    alu_req     = alu_valid && (alu_rdest != ADDR_W'(REG_NONE));
    mem_req     = mem_valid && (mem_rdest != ADDR_W'(REG_NONE));
    collision   = alu_req && mem_req && (alu_rdest == mem_rdest);
    alu_grant   = 1'b0;
    mem_grant   = 1'b0;
    if (collision) begin
      mem_grant = 1'b1;
    end else if (force_alu) begin
      alu_grant = alu_req;
      mem_grant = mem_req && !alu_req;
    end else begin
      mem_grant = mem_req;
      alu_grant = alu_req && !mem_req;
    end
    alu_null_ok = alu_valid && !alu_req;
    mem_null_ok = mem_valid && !mem_req;
    alu_lost    = alu_req && !alu_grant && !force_alu;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: the ALU result path and the memory-load path share one
// register-file write port. The winning write is registered and presented to
// the Rdest decoder and register bank one cycle later. A small loss counter
// forces the ALU to win after MAX_WAIT consecutive losses.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rdest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rdest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rdest,
  output logic [DATA_W-1:0] wb_data,
  output logic              alu_starved
);

  localparam logic [1:0] MAX_WAIT_C = 2'(MAX_WAIT);

  wb_state_t  state;
  wb_state_t  state_nxt;
  logic [1:0] loss_cnt;
  logic [1:0] loss_cnt_nxt;

  logic alu_grant;
  logic mem_grant;
  logic alu_null_ok;
  logic mem_null_ok;
  logic alu_lost;

  wb_grant #(
    .ADDR_W (ADDR_W)
  ) u_grant (
    .alu_valid   (alu_valid),
    .alu_rdest   (alu_rdest),
    .mem_valid   (mem_valid),
    .mem_rdest   (mem_rdest),
    .force_alu   (state == WB_FORCE),
    .alu_grant   (alu_grant),
    .mem_grant   (mem_grant),
    .alu_null_ok (alu_null_ok),
    .mem_null_ok (mem_null_ok),
    .alu_lost    (alu_lost)
  );

  assign alu_ready   = !reset && (alu_grant || alu_null_ok);
  assign mem_ready   = !reset && (mem_grant || mem_null_ok);
  assign alu_starved = (state == WB_FORCE);

  // Next state: an ALU grant always returns to ARB with a cleared counter;
  // a counted loss that reaches MAX_WAIT switches to FORCE.
  always_comb begin
    state_nxt    = state;
    loss_cnt_nxt = loss_cnt;
    if (alu_grant) begin
      state_nxt    = WB_ARB;
      loss_cnt_nxt = 2'd0;
    end else if (alu_lost) begin
      loss_cnt_nxt = loss_cnt + 2'd1;
      if (loss_cnt_nxt == MAX_WAIT_C) begin
        state_nxt = WB_FORCE;
      end
    end
  end

  // Arbiter state and loss counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WB_ARB;
      loss_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      loss_cnt <= loss_cnt_nxt;
    end
  end

  // Registered write port; destination and data hold when no write occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en    <= 1'b0;
      wb_rdest <= '0;
      wb_data  <= '0;
    end else begin
      wb_en <= alu_grant || mem_grant;
      if (mem_grant) begin
        wb_rdest <= mem_rdest;
        wb_data  <= mem_data;
      end else if (alu_grant) begin
        wb_rdest <= alu_rdest;
        wb_data  <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int MAX_WAIT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rdest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rdest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rdest;
  logic [DATA_W-1:0] wb_data;
  logic              alu_starved;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rdest   (alu_rdest),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rdest   (mem_rdest),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .wb_en       (wb_en),
    .wb_rdest    (wb_rdest),
    .wb_data     (wb_data),
    .alu_starved (alu_starved)
  );

  typedef struct packed {
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        e_aready;
    logic        e_mready;
    logic        e_en;
    logic [3:0]  e_rd;
    logic [15:0] e_data;
    logic        e_starved;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Behavioural model: consecutive counted ALU losses and the expected write port
  int          m_loss;
  logic        m_en;
  logic [3:0]  m_rd;
  logic [15:0] m_data;
  logic        m_alu_ready;
  logic        m_mem_ready;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    m_loss      = 0;
    m_en        = 1'b0;
    m_rd        = '0;
    m_data      = '0;
    m_alu_ready = 1'b0;
    m_mem_ready = 1'b0;
  endtask

  task automatic driveInputs(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                             input logic mv, input logic [3:0] mr, input logic [15:0] md);
    alu_valid = av; alu_rdest = ar; alu_data = ad;
    mem_valid = mv; mem_rdest = mr; mem_data = md;
  endtask

  task automatic checkOutput();
    compare("wb_en", wb_en, m_en);
    compare("wb_rdest", wb_rdest, m_rd);
    compare("wb_data", wb_data, m_data);
    compare("alu_starved", alu_starved, m_loss >= MAX_WAIT);
  endtask

  // One clock of traffic: check last cycle's registered result, present the
  // new requests, check the readies, then advance the model.
  task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                               input logic mv, input logic [3:0] mr, input logic [15:0] md);
    bit a_real, m_real, forced, a_win, m_win;
    @(negedge clk);
    checkOutput();
    driveInputs(av, ar, ad, mv, mr, md);
    #1;
    a_real = av && (ar != 4'd0);
    m_real = mv && (mr != 4'd0);
    forced = (m_loss >= MAX_WAIT);
    a_win  = 1'b0;
    m_win  = 1'b0;
    if (a_real && m_real) begin
      if (ar == mr)    m_win = 1'b1;
      else if (forced) a_win = 1'b1;
      else             m_win = 1'b1;
    end else begin
      a_win = a_real;
      m_win = m_real;
    end
    m_alu_ready = a_win || (av && ar == 4'd0);
    m_mem_ready = m_win || (mv && mr == 4'd0);
    compare("alu_ready", alu_ready, m_alu_ready);
    compare("mem_ready", mem_ready, m_mem_ready);
    if (a_win) m_loss = 0;
    else if (a_real && !forced) m_loss = m_loss + 1;
    m_en = a_win || m_win;
    if (m_win) begin
      m_rd = mr; m_data = md;
    end else if (a_win) begin
      m_rd = ar; m_data = ad;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  logic        h_av, h_mv;
  logic [3:0]  h_ar, h_mr;
  logic [15:0] h_ad, h_md;

  initial begin
    reset = 1'b1;
    driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    modelReset();

    //                av  ar     ad        mv  mr     md        ard  mrd  en   rd     data      st
    vecs[0]  = '{1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 1'b0};
    vecs[1]  = '{1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0111, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0111, 1'b0};
    vecs[2]  = '{1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0222, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0222, 1'b1};
    vecs[3]  = '{1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0333, 1'b1, 1'b0, 1'b1, 4'd7, 16'h0777, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h0333, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0333, 1'b0};
    vecs[5]  = '{1'b1, 4'd9, 16'h00BB, 1'b1, 4'd9, 16'h00AA, 1'b0, 1'b1, 1'b1, 4'd9, 16'h00AA, 1'b0};
    vecs[6]  = '{1'b1, 4'd9, 16'h00BB, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9, 16'h00BB, 1'b0};
    vecs[7]  = '{1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd4, 16'h0044, 1'b1, 1'b1, 1'b1, 4'd4, 16'h0044, 1'b0};
    vecs[8]  = '{1'b1, 4'd0, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0044, 1'b0};
    vecs[9]  = '{1'b1, 4'd0, 16'h1111, 1'b1, 4'd0, 16'h2222, 1'b1, 1'b1, 1'b0, 4'd4, 16'h0044, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd4, 16'h0044, 1'b0};

    // Reset state, with requests presented to confirm readies stay low
    @(negedge clk);
    driveInputs(1'b1, 4'd5, 16'h5555, 1'b1, 4'd6, 16'h6666);
    #1;
    compare("reset_alu_ready", alu_ready, 1'b0);
    compare("reset_mem_ready", mem_ready, 1'b0);
    checkOutput();
    @(negedge clk);
    driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      if (i > 0) begin
        compare("vec_wb_en", wb_en, vecs[i-1].e_en);
        compare("vec_wb_rdest", wb_rdest, vecs[i-1].e_rd);
        compare("vec_wb_data", wb_data, vecs[i-1].e_data);
        compare("vec_starved", alu_starved, vecs[i-1].e_starved);
      end
      driveInputs(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      #1;
      compare("vec_alu_ready", alu_ready, vecs[i].e_aready);
      compare("vec_mem_ready", mem_ready, vecs[i].e_mready);
    end
    @(negedge clk);
    compare("vec_wb_en", wb_en, vecs[NVEC-1].e_en);
    compare("vec_wb_rdest", wb_rdest, vecs[NVEC-1].e_rd);
    compare("vec_wb_data", wb_data, vecs[NVEC-1].e_data);

    // Reset mid-stream: grant, one ALU loss, then reset while wb_en is high
    doReset();
    applyStimulus(1'b1, 4'd6, 16'h0606, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0303);
    @(negedge clk);
    checkOutput();
    compare("pre_reset_wb_en", wb_en, 1'b1);
    reset = 1'b1;
    #1;
    compare("async_wb_en", wb_en, 1'b0);
    compare("async_wb_rdest", wb_rdest, 4'd0);
    compare("async_wb_data", wb_data, 16'd0);
    compare("rst_alu_ready", alu_ready, 1'b0);
    compare("rst_mem_ready", mem_ready, 1'b0);
    repeat (2) @(negedge clk);
    compare("rst_hold_alu_ready", alu_ready, 1'b0);
    compare("rst_hold_mem_ready", mem_ready, 1'b0);
    compare("rst_starved", alu_starved, 1'b0);
    driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0310);
    applyStimulus(1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0311);
    applyStimulus(1'b1, 4'd7, 16'h0777, 1'b1, 4'd3, 16'h0312);
    compare("post_reset_force_grant", alu_ready, 1'b1);

    // Idle hold: one ALU loss survives five idle cycles
    applyStimulus(1'b1, 4'd7, 16'h0778, 1'b1, 4'd3, 16'h0312);
    repeat (5) applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b1, 4'd7, 16'h0779, 1'b1, 4'd3, 16'h0320);
    compare("idle_mem_wins", mem_ready, 1'b1);
    applyStimulus(1'b1, 4'd7, 16'h0779, 1'b1, 4'd3, 16'h0321);
    compare("idle_alu_forced", alu_ready, 1'b1);

    // Collision while forced: mem still wins and FORCE persists
    applyStimulus(1'b1, 4'd5, 16'h0505, 1'b1, 4'd6, 16'h0606);
    applyStimulus(1'b1, 4'd5, 16'h0505, 1'b1, 4'd8, 16'h0808);
    applyStimulus(1'b1, 4'd5, 16'h0505, 1'b1, 4'd5, 16'h0A05);
    compare("force_collision_mem", mem_ready, 1'b1);
    applyStimulus(1'b1, 4'd5, 16'h0505, 1'b0, 4'd0, 16'h0000);
    compare("force_after_collision_alu", alu_ready, 1'b1);

    // Randomized traffic; unaccepted requests are held stable
    h_av = 1'b0; h_mv = 1'b0;
    h_ar = '0; h_mr = '0; h_ad = '0; h_md = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(h_av && !m_alu_ready)) begin
        h_av = ($urandom_range(0, 9) < 7);
        h_ar = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        h_ad = 16'($urandom);
      end
      if (!(h_mv && !m_mem_ready)) begin
        h_mv = ($urandom_range(0, 9) < 7);
        h_mr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        h_md = 16'($urandom);
      end
      applyStimulus(h_av, h_ar, h_ad, h_mv, h_mr, h_md);
    end
    @(negedge clk);
    checkOutput();
    driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
